// File: rtl/exu2ifu_pkg.sv
// Shared EXU->IFU redirect definitions: address width defines, FSM state type
// and the PC alignment default shared with IFU.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef ADDR_ZERO
`define ADDR_ZERO {`ADDR_WIDTH{1'b0}}
`endif

package exu2ifu_pkg;

  typedef enum logic [0:0] {
    E2I_IDLE = 1'b0,
    E2I_FULL = 1'b1
  } e2i_state_t;

  localparam int E2I_PC_ALIGN_BITS = 2;

endpackage

// File: rtl/e2i_perf_cnt.sv
// 32-bit event counter with enable; wraps from 0xFFFFFFFF back to zero.
module e2i_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/exu2ifu.sv
// Backward redirect stage EXU->IFU: one-entry register, valid/ready handshake,
// one-cycle flush per accepted redirect. Define E2I_PERF_EN for perf counters.
import exu2ifu_pkg::*;

module exu2ifu #(
  parameter int PC_ALIGN_BITS = E2I_PC_ALIGN_BITS
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst_n,
  input  logic                   i_exu_valid,
  output logic                   o_e2i_ready,
  input  logic                   i_ifu_ready,
  output logic                   o_e2i_valid,
  input  logic [`ADDR_WIDTH-1:0] i_exu_pc,
  output logic [`ADDR_WIDTH-1:0] o_e2i_pc,
  output logic                   o_e2i_misalign,
  output logic                   o_e2i_flush
`ifdef E2I_PERF_EN
  ,
  output logic [31:0]            o_e2i_redirect_cnt,
  output logic [31:0]            o_e2i_stall_cnt
`endif
);

  localparam logic [`ADDR_WIDTH-1:0] LOW_MASK =
    (`ADDR_WIDTH'(1) << PC_ALIGN_BITS) - `ADDR_WIDTH'(1);

  e2i_state_t             state;
  logic [`ADDR_WIDTH-1:0] r_pc;
  logic                   r_misalign;
  logic                   r_flush;
  logic                   accept;
  logic                   deliver;

  // Ready passes IFU ready through while full so a redirect can replace the
  // one being delivered in the same cycle.
  assign o_e2i_valid = (state == E2I_FULL);
  assign o_e2i_ready = (state == E2I_IDLE) || i_ifu_ready;
  assign accept      = i_exu_valid && o_e2i_ready;
  assign deliver     = o_e2i_valid && i_ifu_ready;

  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      state      <= E2I_IDLE;
      r_pc       <= `ADDR_ZERO;
      r_misalign <= 1'b0;
      r_flush    <= 1'b0;
    end else begin
      r_flush <= accept;
      if (accept) begin
        state      <= E2I_FULL;
        r_pc       <= i_exu_pc & ~LOW_MASK;
        r_misalign <= |(i_exu_pc & LOW_MASK);
      end else if (deliver) begin
        state <= E2I_IDLE;
      end
    end
  end

  assign o_e2i_pc       = r_pc;
  assign o_e2i_misalign = r_misalign;
  assign o_e2i_flush    = r_flush;

`ifdef E2I_PERF_EN
  e2i_perf_cnt u_redirect_cnt (
    .clk   (i_sys_clk),
    .rst_n (i_sys_rst_n),
    .en    (accept),
    .count (o_e2i_redirect_cnt)
  );

  e2i_perf_cnt u_stall_cnt (
    .clk   (i_sys_clk),
    .rst_n (i_sys_rst_n),
    .en    (o_e2i_valid && !i_ifu_ready),
    .count (o_e2i_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_exu2ifu.sv
// Directed self-checking bench for exu2ifu; perf counter steps run only when
// E2I_PERF_EN is defined.
module tb_exu2ifu;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   exu_valid;
  logic                   e2i_ready;
  logic                   ifu_ready;
  logic                   e2i_valid;
  logic [`ADDR_WIDTH-1:0] exu_pc;
  logic [`ADDR_WIDTH-1:0] e2i_pc;
  logic                   e2i_misalign;
  logic                   e2i_flush;
`ifdef E2I_PERF_EN
  logic [31:0]            redirect_cnt;
  logic [31:0]            stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  exu2ifu dut (
    .i_sys_clk      (clk),
    .i_sys_rst_n    (rst_n),
    .i_exu_valid    (exu_valid),
    .o_e2i_ready    (e2i_ready),
    .i_ifu_ready    (ifu_ready),
    .o_e2i_valid    (e2i_valid),
    .i_exu_pc       (exu_pc),
    .o_e2i_pc       (e2i_pc),
    .o_e2i_misalign (e2i_misalign),
    .o_e2i_flush    (e2i_flush)
`ifdef E2I_PERF_EN
    ,
    .o_e2i_redirect_cnt (redirect_cnt),
    .o_e2i_stall_cnt    (stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic v,
                               input logic [31:0] pc, input logic ir);
    rst_n     = rst;
    exu_valid = v;
    exu_pc    = pc;
    ifu_ready = ir;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic v, input logic [31:0] pc,
                            input logic fl, input logic mis);
    checkOutput({tag, "_valid"}, 32'(e2i_valid), 32'(v));
    checkOutput({tag, "_pc"}, e2i_pc, pc);
    checkOutput({tag, "_flush"}, 32'(e2i_flush), 32'(fl));
    checkOutput({tag, "_misalign"}, 32'(e2i_misalign), 32'(mis));
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1, 32'h8000_0010, 1'b1);

    // Reset held for three cycles with EXU requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      checkState("reset", 1'b0, 32'h0, 1'b0, 1'b0);
      checkOutput("reset_ready", 32'(e2i_ready), 32'd1);
    end

    // Single redirect.
    applyStimulus(1'b1, 1'b1, 32'h8000_0010, 1'b1);
    tick();
    checkState("single", 1'b1, 32'h8000_0010, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkState("single_done", 1'b0, 32'h8000_0010, 1'b0, 1'b0);

    // Backpressure for four cycles.
    applyStimulus(1'b1, 1'b1, 32'h8000_0040, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
    checkState("bp_first", 1'b1, 32'h8000_0040, 1'b1, 1'b0);
    checkOutput("bp_first_ready", 32'(e2i_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkState("bp_hold", 1'b1, 32'h8000_0040, 1'b0, 1'b0);
      checkOutput("bp_hold_ready", 32'(e2i_ready), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("bp_release_ready", 32'(e2i_ready), 32'd1);
    tick();
    checkState("bp_done", 1'b0, 32'h8000_0040, 1'b0, 1'b0);

    // Back-to-back redirects.
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b0);
    tick();
    checkState("b2b_first", 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h0000_0200, 1'b1);
    checkOutput("b2b_ready", 32'(e2i_ready), 32'd1);
    tick();
    checkState("b2b_second", 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkState("b2b_done", 1'b0, 32'h0000_0200, 1'b0, 1'b0);

    // Misaligned target, then aligned one clears the flag.
    applyStimulus(1'b1, 1'b1, 32'h8000_0006, 1'b1);
    tick();
    checkState("misalign", 1'b1, 32'h8000_0004, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h8000_0008, 1'b1);
    tick();
    checkState("realign", 1'b1, 32'h8000_0008, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    checkState("realign_done", 1'b0, 32'h8000_0008, 1'b0, 1'b0);

    // Reset while full discards the pending redirect.
    applyStimulus(1'b1, 1'b1, 32'h0000_0300, 1'b0);
    tick();
    checkState("mid_full", 1'b1, 32'h0000_0300, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    tick();
    checkState("mid_reset", 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef E2I_PERF_EN
    checkOutput("cnt_reset_redirect", redirect_cnt, 32'd0);
    checkOutput("cnt_reset_stall", stall_cnt, 32'd0);
    // Three redirects stalled for 2, 3 and 0 cycles.
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b1, 1'b1, 32'h0000_1000 + 32'(r * 16), 1'b1);
      tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
      for (int s = 0; s < (r == 0 ? 2 : (r == 1 ? 3 : 0)); s++) tick();
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
      tick();
    end
    checkOutput("cnt_redirect", redirect_cnt, 32'd3);
    checkOutput("cnt_stall", stall_cnt, 32'd5);
    force dut.u_redirect_cnt.count = 32'hFFFF_FFFF;
    #1;
    release dut.u_redirect_cnt.count;
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 1'b1);
    tick();
    checkOutput("cnt_wrap", redirect_cnt, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
`else
    applyStimulus(1'b1, 1'b1, 32'h0000_0020, 1'b1);
    tick();
    checkState("post_reset", 1'b1, 32'h0000_0020, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
`endif
    checkOutput("final_idle", 32'(e2i_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
